// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
`timescale 1ns/1ps
package modexp_pkg;

    // Width of the busy-cycle counter exported for timing measurement.
    localparam int CNT_W = 32;

    // Sequencer states. Each request state pairs with a wait state.
    typedef enum logic [3:0] {
        IDLE,
        RED,
        RED_W,
        SQ,
        SQ_W,
        MUL,
        MUL_W,
        NEXT,
        FIN
    } state_t;

    // Exponent/modulus/operand width derived from the message width.
    function automatic int ew_of(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller for c^d mod n.
// All products go through an external req/done modular multiplier.
// The exponent bit step is resolved in the same cycle as mul_done, so
// NEXT is never occupied and each operation costs exactly L+1 cycles.
`timescale 1ns/1ps
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 ct_mode,
    input  logic [WIDTH-1:0]     c,
    input  logic [2*WIDTH-1:0]   d,
    input  logic [2*WIDTH-1:0]   n,
    output logic                 mul_req,
    output logic [2*WIDTH-1:0]   mul_a,
    output logic [2*WIDTH-1:0]   mul_b,
    output logic [2*WIDTH-1:0]   mul_n,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     cycle_cnt
);

    localparam int EW    = ew_of(WIDTH);
    localparam int IDX_W = $clog2(EW);

    state_t           state;
    state_t           next_state;
    logic [EW-1:0]    exp_sr;
    logic [IDX_W-1:0] idx;
    logic [EW-1:0]    r;
    logic [EW-1:0]    b;
    logic             ct_reg;

    logic             cur_bit;
    logic             need_mul;
    logic             last_bit;
    logic             small_n;
    logic [EW-1:0]    r_after_mul;

    assign cur_bit     = exp_sr[EW-1];
    assign need_mul    = cur_bit | ct_reg;
    assign last_bit    = (idx == '0);
    assign small_n     = (n < EW'(2));
    assign r_after_mul = cur_bit ? mul_p : r;

    assign mul_req = (state == RED) || (state == SQ) || (state == MUL);
    assign done    = (state == FIN);
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the NEXT step is folded into the wait-state exits.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = small_n ? FIN : RED;
            RED:     next_state = RED_W;
            RED_W:   if (mul_done) next_state = SQ;
            SQ:      next_state = SQ_W;
            SQ_W: begin
                if (mul_done) begin
                    if (need_mul)      next_state = MUL;
                    else if (last_bit) next_state = FIN;
                    else               next_state = SQ;
                end
            end
            MUL:     next_state = MUL_W;
            MUL_W:   if (mul_done) next_state = last_bit ? FIN : SQ;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand launch, accumulator update, exponent walk, counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_sr    <= '0;
            idx       <= '0;
            r         <= '0;
            b         <= '0;
            ct_reg    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_n     <= '0;
            result    <= '0;
            err       <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_sr    <= d;
                        idx       <= IDX_W'(EW - 1);
                        mul_n     <= n;
                        ct_reg    <= ct_mode;
                        r         <= EW'(1);
                        err       <= (n == '0);
                        cycle_cnt <= CNT_W'(1);
                        if (small_n) begin
                            result <= '0;
                        end else begin
                            mul_a <= EW'(c);
                            mul_b <= EW'(1);
                        end
                    end
                end
                RED_W: begin
                    if (mul_done) begin
                        b     <= mul_p;
                        mul_a <= r;
                        mul_b <= r;
                    end
                end
                SQ_W: begin
                    if (mul_done) begin
                        r <= mul_p;
                        if (need_mul) begin
                            mul_a <= mul_p;
                            mul_b <= b;
                        end else if (last_bit) begin
                            result <= mul_p;
                        end else begin
                            exp_sr <= exp_sr << 1;
                            idx    <= idx - IDX_W'(1);
                            mul_a  <= mul_p;
                            mul_b  <= mul_p;
                        end
                    end
                end
                MUL_W: begin
                    if (mul_done) begin
                        r <= r_after_mul;
                        if (last_bit) begin
                            result <= r_after_mul;
                        end else begin
                            exp_sr <= exp_sr << 1;
                            idx    <= idx - IDX_W'(1);
                            mul_a  <= r_after_mul;
                            mul_b  <= r_after_mul;
                        end
                    end
                end
                default: ;
            endcase
            if (state != IDLE && state != FIN) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl with a latency-2 multiplier model.
`timescale 1ns/1ps
module tb_modexp_ctrl;

    localparam int WIDTH = 8;
    localparam int EW    = 2 * WIDTH;
    localparam int LAT   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            ct_mode = 1'b0;
    logic [WIDTH-1:0] c = '0;
    logic [EW-1:0]   d = '0;
    logic [EW-1:0]   n = '0;
    logic            mul_req;
    logic [EW-1:0]   mul_a;
    logic [EW-1:0]   mul_b;
    logic [EW-1:0]   mul_n;
    logic            mul_done = 1'b0;
    logic [EW-1:0]   mul_p = '0;
    logic [EW-1:0]   result;
    logic            done;
    logic            busy;
    logic            err;
    logic [31:0]     cycle_cnt;

    int checks_total = 0;
    int checks_passed = 0;

    // Expectations for the run in flight, produced by the bench model.
    longint exp_result = 0;
    longint exp_err = 0;
    longint exp_ops = 0;
    longint exp_cnt = 0;
    longint exp_n = 0;
    int     run_seq = 0;
    int     done_seq = 0;
    int     last_reqs = 0;
    int     spur_req = 0;

    modexp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ct_mode(ct_mode),
        .c(c), .d(d), .n(n),
        .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
        .mul_done(mul_done), .mul_p(mul_p),
        .result(result), .done(done), .busy(busy), .err(err),
        .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Plain square-and-multiply over every exponent bit.
    function automatic longint model_exp(input longint cv, input longint dv, input longint nv);
        longint rr;
        longint bb;
        if (nv < 2) return 0;
        rr = 1;
        bb = cv % nv;
        for (int i = EW - 1; i >= 0; i--) begin
            rr = (rr * rr) % nv;
            if (((dv >> i) & 1) == 1) rr = (rr * bb) % nv;
        end
        return rr;
    endfunction

    // Multiplier model: answers each request LAT cycles later and
    // checks that the operands are held while it works.
    longint cap_a = 0;
    longint cap_b = 0;
    longint cap_n = 0;
    int     pend = 0;
    int     spur_ack = 0;
    always @(negedge clk) begin
        mul_done = 1'b0;
        if (pend > 0) begin
            if (busy) begin
                checkOutput("hold_mul_a", mul_a, cap_a);
                checkOutput("hold_mul_b", mul_b, cap_b);
                checkOutput("hold_mul_n", mul_n, cap_n);
            end
            pend--;
            if (pend == 0) begin
                mul_done = 1'b1;
                mul_p = (cap_n != 0) ? EW'((cap_a * cap_b) % cap_n) : '0;
            end
        end else if (spur_req != spur_ack) begin
            spur_ack = spur_req;
            mul_done = 1'b1;
            mul_p = 16'h1234;
        end
        if (mul_req) begin
            cap_a = mul_a;
            cap_b = mul_b;
            cap_n = mul_n;
            pend = LAT;
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model's timing rules.
    bit active = 0;
    int cyc = 0;
    int req_seen = 0;
    always @(negedge clk) begin
        if (!active && run_seq != done_seq) begin
            active = 1;
            cyc = 0;
            req_seen = 0;
        end
        if (active) begin
            if (cyc == 0) begin
                checkOutput("idle_before_run", busy, 0);
            end else if (cyc <= exp_cnt) begin
                checkOutput("busy_in_run", busy, 1);
                checkOutput("done_timing", done, (cyc == exp_cnt) ? 1 : 0);
                checkOutput("req_timing", mul_req,
                    ((cyc <= exp_ops * (LAT + 1)) && ((cyc - 1) % (LAT + 1) == 0)) ? 1 : 0);
                checkOutput("mul_n_copy", mul_n, exp_n);
                if (mul_req) req_seen++;
                if (cyc == exp_cnt) begin
                    checkOutput("result_at_done", result, exp_result);
                    checkOutput("err_at_done", err, exp_err);
                    checkOutput("req_count", req_seen, exp_ops);
                    last_reqs = req_seen;
                end
            end else begin
                checkOutput("busy_after_done", busy, 0);
                checkOutput("done_after", done, 0);
                checkOutput("result_held", result, exp_result);
                checkOutput("err_held", err, exp_err);
                checkOutput("cycle_cnt_final", cycle_cnt, exp_cnt);
                active = 0;
                done_seq = run_seq;
            end
            cyc++;
        end
    end

    // Launch one run, optionally poke start again while busy, wait for it.
    task automatic applyStimulus(input logic [WIDTH-1:0] cv, input logic [EW-1:0] dv,
                                 input logic [EW-1:0] nv, input logic ctv, input int poke);
        exp_result = model_exp(cv, dv, nv);
        exp_err    = (nv == 0) ? 1 : 0;
        exp_ops    = (nv < 2) ? 0 : (ctv ? 1 + 2 * EW : 1 + EW + $countones(dv));
        exp_cnt    = (nv < 2) ? 1 : exp_ops * (LAT + 1) + 1;
        exp_n      = nv;
        @(posedge clk); #1;
        c = cv; d = dv; n = nv; ct_mode = ctv; start = 1'b1;
        run_seq++;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke > 0) begin
            repeat (poke - 1) @(posedge clk);
            #1;
            c = 8'd3; d = 16'd2; n = 16'd5; ct_mode = ~ctv; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int k = 0; k < exp_cnt + 20 && done_seq != run_seq; k++) @(posedge clk);
        if (done_seq != run_seq) begin
            checkOutput("run_timeout", done_seq, run_seq);
            $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
            $fatal(1, "[TB] run did not complete");
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_result", result, 0);
        checkOutput("rst_cycle_cnt", cycle_cnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_mul_req", mul_req, 0);
        checkOutput("rst_mul_a", mul_a, 0);
        checkOutput("rst_mul_b", mul_b, 0);
        checkOutput("rst_mul_n", mul_n, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 5^3 mod 33, normal mode, pinned with hand-computed literals.
        applyStimulus(8'd5, 16'd3, 16'd33, 1'b0, 0);
        checkOutput("lit_result_normal", result, 26);
        checkOutput("lit_cnt_normal", cycle_cnt, 58);
        checkOutput("lit_reqs_normal", last_reqs, 19);

        // Constant-time mode: same answer, fixed cost.
        applyStimulus(8'd5, 16'd3, 16'd33, 1'b1, 0);
        checkOutput("lit_result_ct", result, 26);
        checkOutput("lit_cnt_ct", cycle_cnt, 100);
        checkOutput("lit_reqs_ct", last_reqs, 33);
        applyStimulus(8'd5, 16'hFFFF, 16'd33, 1'b1, 0);
        checkOutput("lit_cnt_ct_ffff", cycle_cnt, 100);

        // Base larger than modulus, and zero exponent.
        applyStimulus(8'd200, 16'd1, 16'd7, 1'b0, 0);
        checkOutput("lit_result_reduce", result, 4);
        applyStimulus(8'd5, 16'd0, 16'd33, 1'b0, 0);
        checkOutput("lit_result_d0", result, 1);

        // Degenerate moduli short-circuit in one cycle.
        applyStimulus(8'd9, 16'd5, 16'd0, 1'b0, 0);
        checkOutput("lit_err_n0", err, 1);
        checkOutput("lit_cnt_n0", cycle_cnt, 1);
        applyStimulus(8'd9, 16'd5, 16'd1, 1'b0, 0);
        checkOutput("lit_err_n1", err, 0);
        checkOutput("lit_result_n1", result, 0);

        // Start while busy must not disturb the run in flight.
        applyStimulus(8'd7, 16'h000B, 16'd55, 1'b0, 10);

        // Spurious mul_done in IDLE must have no effect.
        @(posedge clk); #1;
        spur_req++;
        @(posedge clk); #1;
        checkOutput("spur_busy", busy, 0);
        checkOutput("spur_done", done, 0);
        checkOutput("spur_req", mul_req, 0);
        checkOutput("spur_result", result, exp_result);

        // Reset while waiting on the first square.
        @(posedge clk); #1;
        c = 8'd5; d = 16'd3; n = 16'd33; ct_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_mul_req", mul_req, 0);
        checkOutput("mid_rst_result", result, 0);
        checkOutput("mid_rst_cycle_cnt", cycle_cnt, 0);
        checkOutput("mid_rst_mul_a", mul_a, 0);
        checkOutput("mid_rst_mul_n", mul_n, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("late_done_busy", busy, 0);
        checkOutput("late_done_result", result, 0);
        applyStimulus(8'd5, 16'd3, 16'd33, 1'b0, 0);
        checkOutput("lit_result_after_rst", result, 26);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencing controller for RSA modular exponentiation, m = c^d mod n. It computes the result by left-to-right square-and-multiply. Every modular product is issued to one external, variable-latency modular multiplier through a req/done handshake. A per-run constant-time mode always issues the multiply step and discards it when the exponent bit is 0, so the timing side channel can be enabled or closed. A busy-cycle counter is exported for timing measurement.

## Interface
- WIDTH, default 8: message width. Exponent, modulus and internal operands are 2*WIDTH bits (EW = 2*WIDTH).
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- ct_mode  input  1  constant-time select; sampled together with start
- c  input  WIDTH  ciphertext (base)
- d  input  2*WIDTH  private exponent
- n  input  2*WIDTH  modulus
- mul_req  output  1  one-cycle pulse; operands valid that cycle, held stable until mul_done
- mul_a, mul_b  output  2*WIDTH  multiplier operands
- mul_n  output  2*WIDTH  modulus to multiplier (registered copy of n)
- mul_done  input  1  one-cycle pulse; mul_p valid in that cycle
- mul_p  input  2*WIDTH  (mul_a*mul_b) mod mul_n
- result  output  2*WIDTH  c^d mod n; held until next accepted start
- done  output  1  one-cycle pulse when result is valid
- busy  output  1  run in progress
- err  output  1  set with done when n==0; cleared on next start
- cycle_cnt  output  32  busy cycles of the last or current run

## Operation
- Reset: state IDLE. All outputs are 0: result, cycle_cnt, busy, done, err, mul_req, mul_a, mul_b, mul_n.
- IDLE, start=1: latch c, d (into a shift register), n and ct_mode. Clear err and cycle_cnt. Set bit index to EW-1 and r=1.
- n==0: go to FIN with result=0, err=1. No mul_req is issued.
- n==1: go to FIN with result=0, err=0. No mul_req is issued.
- RED: issue (c, 1) to reduce the base. On mul_done, b=mul_p.
- SQ: issue (r, r). On mul_done, r=mul_p.
- MUL step (runs when the exponent bit is 1, or when ct_mode=1):
  - Issue (r, b).
  - On mul_done, r=mul_p if the bit is 1; otherwise discard mul_p (dummy multiply).
- NEXT:
  - Index 0: go to FIN.
  - Otherwise: shift the exponent, decrement the index, go to SQ.
- All EW bits are processed from the MSB; leading zeros are not skipped. d=0 gives r=1.
- FIN: result=r, done=1 for one cycle, then IDLE.
- Each request state (RED, SQ, MUL) has a paired wait state. The request state pulses mul_req for one cycle and then waits for mul_done.
- The controller holds mul_a, mul_b and mul_n stable from mul_req through mul_done.
- mul_done while not waiting is ignored.
- start while busy is ignored.
- Operation count:
  - Normal mode: 1 + EW + popcount(d).
  - ct_mode: 1 + 2*EW, independent of d.

## Timing
- Multiplier latency L ≥ 1: mul_done arrives L cycles after mul_req.
- Cycle 0: start is sampled.
- Cycle 1: busy=1 and the first mul_req is issued.
- Each operation occupies L+1 cycles. The next mul_req follows the mul_done cycle by exactly one cycle.
- done is asserted in cycle OPS*(L+1)+1. busy is still 1 in that cycle and 0 in the next.
- cycle_cnt increments in every busy cycle, so its final value is OPS*(L+1)+1. It holds until the next start.
- n<2 short-circuit: done in cycle 1, cycle_cnt=1.
- A new start is accepted in the cycle after done.
- rst_n low mid-run: immediate return to IDLE with all outputs 0. Any late mul_done is ignored.

## Structure
- Package modexp_pkg holds:
  - the state enum: IDLE, RED, RED_W, SQ, SQ_W, MUL, MUL_W, NEXT, FIN;
  - the EW localparam function;
  - the cycle_cnt width constant (32).
- Single module with no sub-module. The exponent shift register and the bit index are inline.
- The modular multiplier is a sibling block, instantiated by the parent RSA wrapper.

## Test plan
Bench model: multiplier with L=2, WIDTH=8.
- c=5, d=3, n=33, ct_mode=0 → result=26 (0x001A); 19 mul_req pulses; cycle_cnt=58.
- Same inputs, ct_mode=1 → result=26; 33 mul_req pulses; cycle_cnt=100. Repeat with d=0xFFFF: identical cycle_cnt.
- c=200, d=1, n=7 → result=4 (RED reduces the base to 4). d=0, n=33 → result=1.
- n=0 → done in cycle 1, err=1, result=0, no mul_req. n=1 → done in cycle 1, err=0, result=0.
- start pulsed while busy → ignored, run completes unchanged. Spurious mul_done in IDLE → no effect.
- rst_n low during SQ_W → all outputs 0 immediately. A fresh start afterwards yields the correct result.
